// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending controller.
//   vend_state_t : controller FSM states
//   COIN5/10/25  : coin values in cents
//   price_lookup : maps a 2-bit item index to its price
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_t;

  localparam int unsigned COIN5  = 5;
  localparam int unsigned COIN10 = 10;
  localparam int unsigned COIN25 = 25;

  function automatic int unsigned price_lookup(
    input logic [1:0]  item,
    input int unsigned p0,
    input int unsigned p1,
    input int unsigned p2,
    input int unsigned p3
  );
    case (item)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return p3;
    endcase
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// vend_credit_acc: sums the coin pulses of one cycle, checks the result
// against the credit ceiling and produces the registered reject strobe.
//   clk_dst, rstn          : clock, async active-low reset
//   coin5_p/10_p/25_p      : synchronized coin pulses
//   accept_en              : controller is able to take coins this cycle
//   credit                 : current credit
//   add_amt                : amount to add to credit this cycle (0 if refused)
//   coin_reject_p          : registered strobe, coins of the previous cycle refused
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 7,
  parameter int unsigned MAX_CREDIT = 95
) (
  input  logic                clk_dst,
  input  logic                rstn,
  input  logic                coin5_p,
  input  logic                coin10_p,
  input  logic                coin25_p,
  input  logic                accept_en,
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] add_amt,
  output logic                coin_reject_p
);

  // One extra bit so credit+sum never wraps before the ceiling compare.
  localparam int unsigned SW = CREDIT_W + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] total;
  logic          any_coin;
  logic          take;

  always_comb begin
    sum      = (coin5_p  ? SW'(COIN5)  : '0)
             + (coin10_p ? SW'(COIN10) : '0)
             + (coin25_p ? SW'(COIN25) : '0);
    total    = {1'b0, credit} + sum;
    any_coin = coin5_p | coin10_p | coin25_p;
    // All-or-nothing: the whole cycle's coins are credited or none are.
    take     = accept_en && (total <= SW'(MAX_CREDIT));
    add_amt  = take ? sum[CREDIT_W-1:0] : '0;
  end

  always_ff @(posedge clk_dst or negedge rstn) begin
    if (!rstn) coin_reject_p <= 1'b0;
    else       coin_reject_p <= any_coin && !take;
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine controller. Accumulates coin credit, accepts
// item selections, strobes the dispenser and hands change to the hopper
// through a valid/ack handshake. All outputs are registered.
//   clk_dst, rstn           : clock, async active-low reset
//   coin*_p, cancel_p       : synchronized single-cycle pulses
//   sel_valid, sel_item     : selection request (level)
//   change_ack              : hopper took change_amt
//   credit                  : current credit
//   dispense_p/_item        : dispense strobe and item index
//   change_valid/_amt       : pending change and its value
//   coin_reject_p, short_p  : refused-coin and insufficient-credit strobes
// Build option: define VEND_CANCEL_EN to let cancel_p return credit from
// the CREDIT state; otherwise cancel_p is ignored.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = 15,
  parameter int unsigned PRICE1     = 25,
  parameter int unsigned PRICE2     = 35,
  parameter int unsigned PRICE3     = 50,
  parameter int unsigned MAX_CREDIT = 95,
  parameter int unsigned CREDIT_W   = 7
) (
  input  logic                clk_dst,
  input  logic                rstn,
  input  logic                coin5_p,
  input  logic                coin10_p,
  input  logic                coin25_p,
  input  logic                cancel_p,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense_p,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject_p,
  output logic                short_p
);

  vend_state_t         state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt, amt_nxt, add_amt, price;
  logic                cv_nxt, disp_nxt, short_nxt, accept_en, cancel_go;
  logic [1:0]          item_nxt;

`ifdef VEND_CANCEL_EN
  assign cancel_go = cancel_p && (state == CREDIT);
`else
  logic unused_cancel;
  assign unused_cancel = cancel_p;
  assign cancel_go     = 1'b0;
`endif

  // A cancelling cycle credits no coins, so those coins are refused.
  assign accept_en = ((state == IDLE) || (state == CREDIT)) && !cancel_go;
  assign price     = CREDIT_W'(price_lookup(sel_item, PRICE0, PRICE1, PRICE2, PRICE3));

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_acc (
    .clk_dst       (clk_dst),
    .rstn          (rstn),
    .coin5_p       (coin5_p),
    .coin10_p      (coin10_p),
    .coin25_p      (coin25_p),
    .accept_en     (accept_en),
    .credit        (credit),
    .add_amt       (add_amt),
    .coin_reject_p (coin_reject_p)
  );

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    amt_nxt    = change_amt;
    cv_nxt     = change_valid;
    item_nxt   = dispense_item;
    disp_nxt   = 1'b0;
    short_nxt  = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (cancel_go) begin
          state_nxt  = CHANGE;
          amt_nxt    = credit;
          credit_nxt = '0;
          cv_nxt     = 1'b1;
        end else if (sel_valid && (credit >= price)) begin
          // Affordability uses pre-coin credit; same-cycle coins still count.
          credit_nxt = credit + add_amt - price;
          state_nxt  = DISPENSE;
          disp_nxt   = 1'b1;
          item_nxt   = sel_item;
        end else begin
          credit_nxt = credit + add_amt;
          short_nxt  = sel_valid;
          state_nxt  = (credit_nxt == '0) ? IDLE : CREDIT;
        end
      end
      DISPENSE: begin
        if (credit != '0) begin
          state_nxt  = CHANGE;
          amt_nxt    = credit;
          credit_nxt = '0;
          cv_nxt     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CHANGE: begin
        if (change_ack) begin
          state_nxt = IDLE;
          cv_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_dst or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      credit        <= '0;
      change_amt    <= '0;
      change_valid  <= 1'b0;
      dispense_p    <= 1'b0;
      dispense_item <= 2'd0;
      short_p       <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit        <= credit_nxt;
      change_amt    <= amt_nxt;
      change_valid  <= cv_nxt;
      dispense_p    <= disp_nxt;
      dispense_item <= item_nxt;
      short_p       <= short_nxt;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for vend_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so each step() shows the effect of the previous cycle's inputs.
module tb_vend_ctrl;

  logic       clk_dst = 1'b0;
  logic       rstn = 1'b0;
  logic       coin5_p = 0, coin10_p = 0, coin25_p = 0, cancel_p = 0;
  logic       sel_valid = 0, change_ack = 0;
  logic [1:0] sel_item = 0;
  logic [6:0] credit, change_amt;
  logic       dispense_p, change_valid, coin_reject_p, short_p;
  logic [1:0] dispense_item;

  int checks = 0;
  int failures = 0;

  vend_ctrl dut (
    .clk_dst(clk_dst), .rstn(rstn),
    .coin5_p(coin5_p), .coin10_p(coin10_p), .coin25_p(coin25_p),
    .cancel_p(cancel_p), .sel_valid(sel_valid), .sel_item(sel_item),
    .change_ack(change_ack), .credit(credit),
    .dispense_p(dispense_p), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject_p(coin_reject_p), .short_p(short_p)
  );

  always #5 clk_dst = ~clk_dst;

  task automatic step();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic coin(input logic c5, input logic c10, input logic c25);
    coin5_p = c5; coin10_p = c10; coin25_p = c25;
    step();
    coin5_p = 0; coin10_p = 0; coin25_p = 0;
  endtask

  task automatic select(input logic [1:0] item);
    sel_valid = 1; sel_item = item;
    step();
    sel_valid = 0;
  endtask

  task automatic ack();
    change_ack = 1;
    step();
    change_ack = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    step(); step();
    checks++; if (credit !== 7'd0 || change_amt !== 7'd0) begin failures++;
      $display("FAIL reset_regs credit=%0d amt=%0d exp 0/0", credit, change_amt); end
    checks++; if ({dispense_p, change_valid, coin_reject_p, short_p, dispense_item} !== 6'b0) begin failures++;
      $display("FAIL reset_strobes got=%b exp=000000", {dispense_p, change_valid, coin_reject_p, short_p, dispense_item}); end
    rstn = 1;
    step();
  endtask

  task automatic test_exact_purchase();
    coin(0, 1, 0);
    checks++; if (credit !== 7'd10) begin failures++; $display("FAIL coin10 credit got=%0d exp=10", credit); end
    coin(1, 0, 0);
    checks++; if (credit !== 7'd15) begin failures++; $display("FAIL coin5 credit got=%0d exp=15", credit); end
    select(2'd0);
    checks++; if (dispense_p !== 1'b1 || dispense_item !== 2'd0 || credit !== 7'd0) begin failures++;
      $display("FAIL exact_dispense disp=%b item=%0d credit=%0d exp 1/0/0", dispense_p, dispense_item, credit); end
    step();
    checks++; if (dispense_p !== 1'b0 || change_valid !== 1'b0 || credit !== 7'd0) begin failures++;
      $display("FAIL exact_after disp=%b cv=%b credit=%0d exp 0/0/0", dispense_p, change_valid, credit); end
  endtask

  task automatic test_change();
    coin(0, 0, 1);
    coin(0, 0, 1);
    checks++; if (credit !== 7'd50) begin failures++; $display("FAIL change_credit got=%0d exp=50", credit); end
    select(2'd1);
    checks++; if (dispense_p !== 1'b1 || dispense_item !== 2'd1 || credit !== 7'd25) begin failures++;
      $display("FAIL change_dispense disp=%b item=%0d credit=%0d exp 1/1/25", dispense_p, dispense_item, credit); end
    step();
    checks++; if (change_valid !== 1'b1 || change_amt !== 7'd25 || credit !== 7'd0 || dispense_p !== 1'b0) begin failures++;
      $display("FAIL change_entry cv=%b amt=%0d credit=%0d disp=%b exp 1/25/0/0", change_valid, change_amt, credit, dispense_p); end
    step(); step(); step();
    checks++; if (change_valid !== 1'b1 || change_amt !== 7'd25) begin failures++;
      $display("FAIL change_hold cv=%b amt=%0d exp 1/25", change_valid, change_amt); end
    ack();
    checks++; if (change_valid !== 1'b0) begin failures++; $display("FAIL change_ack cv=%b exp=0", change_valid); end
    // Back in IDLE: a coin is credited again
    coin(1, 0, 0);
    checks++; if (credit !== 7'd5 || coin_reject_p !== 1'b0) begin failures++;
      $display("FAIL change_idle credit=%0d rej=%b exp 5/0", credit, coin_reject_p); end
    select(2'd0); // short: 5 < 15
    coin(0, 1, 0);
    select(2'd0); // exact 15
    step();
  endtask

  task automatic test_ceiling();
    coin(0, 0, 1); coin(0, 0, 1); coin(0, 0, 1); coin(0, 1, 0); coin(1, 0, 0);
    checks++; if (credit !== 7'd90) begin failures++; $display("FAIL ceil_build credit=%0d exp=90", credit); end
    coin(0, 1, 0);
    checks++; if (coin_reject_p !== 1'b1 || credit !== 7'd90) begin failures++;
      $display("FAIL ceil_reject rej=%b credit=%0d exp 1/90", coin_reject_p, credit); end
    coin(1, 0, 0);
    checks++; if (coin_reject_p !== 1'b0 || credit !== 7'd95) begin failures++;
      $display("FAIL ceil_exact rej=%b credit=%0d exp 0/95", coin_reject_p, credit); end
    select(2'd3);
    step();
    checks++; if (change_valid !== 1'b1 || change_amt !== 7'd45) begin failures++;
      $display("FAIL ceil_change cv=%b amt=%0d exp 1/45", change_valid, change_amt); end
    ack();
    coin(1, 1, 1);
    checks++; if (credit !== 7'd40 || coin_reject_p !== 1'b0) begin failures++;
      $display("FAIL multi_coin credit=%0d rej=%b exp 40/0", credit, coin_reject_p); end
    select(2'd2);
    step();
    checks++; if (change_amt !== 7'd5) begin failures++; $display("FAIL multi_change amt=%0d exp=5", change_amt); end
    ack();
  endtask

  task automatic test_short();
    coin(0, 1, 0); coin(0, 1, 0);
    sel_valid = 1; sel_item = 2'd2;
    step();
    checks++; if (short_p !== 1'b1 || credit !== 7'd20 || dispense_p !== 1'b0) begin failures++;
      $display("FAIL short_first short=%b credit=%0d disp=%b exp 1/20/0", short_p, credit, dispense_p); end
    coin5_p = 1;
    step();
    coin5_p = 0; sel_valid = 0;
    checks++; if (short_p !== 1'b1 || credit !== 7'd25) begin failures++;
      $display("FAIL short_repeat short=%b credit=%0d exp 1/25", short_p, credit); end
    step();
    checks++; if (short_p !== 1'b0) begin failures++; $display("FAIL short_clear short=%b exp=0", short_p); end
    select(2'd1);
    step();
  endtask

  task automatic test_coin_in_change();
    coin(0, 0, 1); coin(0, 0, 1);
    select(2'd0);
    checks++; if (credit !== 7'd35) begin failures++; $display("FAIL cic_dispense credit=%0d exp=35", credit); end
    coin(0, 0, 1); // arrives during DISPENSE
    checks++; if (coin_reject_p !== 1'b1 || change_amt !== 7'd35) begin failures++;
      $display("FAIL cic_dispense_rej rej=%b amt=%0d exp 1/35", coin_reject_p, change_amt); end
    coin(0, 0, 1); // arrives during CHANGE
    checks++; if (coin_reject_p !== 1'b1 || change_amt !== 7'd35 || credit !== 7'd0 || change_valid !== 1'b1) begin failures++;
      $display("FAIL cic_change_rej rej=%b amt=%0d credit=%0d cv=%b exp 1/35/0/1", coin_reject_p, change_amt, credit, change_valid); end
    ack();
  endtask

  task automatic test_cancel();
    coin(0, 0, 1); coin(0, 1, 0);
`ifdef VEND_CANCEL_EN
    cancel_p = 1; sel_valid = 1; sel_item = 2'd0;
    step();
    cancel_p = 0; sel_valid = 0;
    checks++; if (dispense_p !== 1'b0 || change_valid !== 1'b1 || change_amt !== 7'd35 || credit !== 7'd0) begin failures++;
      $display("FAIL cancel disp=%b cv=%b amt=%0d credit=%0d exp 0/1/35/0", dispense_p, change_valid, change_amt, credit); end
    ack();
`else
    cancel_p = 1;
    step();
    cancel_p = 0;
    checks++; if (change_valid !== 1'b0 || credit !== 7'd35 || dispense_p !== 1'b0) begin failures++;
      $display("FAIL cancel_off cv=%b credit=%0d disp=%b exp 0/35/0", change_valid, credit, dispense_p); end
    select(2'd2);
    step();
`endif
  endtask

  task automatic test_reset_in_change();
    coin(0, 0, 1);
    select(2'd0);
    step();
    checks++; if (change_valid !== 1'b1 || change_amt !== 7'd10) begin failures++;
      $display("FAIL rst_setup cv=%b amt=%0d exp 1/10", change_valid, change_amt); end
    #2 rstn = 0;
    #1;
    checks++; if (change_valid !== 1'b0 || credit !== 7'd0 || change_amt !== 7'd0) begin failures++;
      $display("FAIL rst_async cv=%b credit=%0d amt=%0d exp 0/0/0", change_valid, credit, change_amt); end
    step();
    rstn = 1;
    coin(1, 0, 0);
    checks++; if (credit !== 7'd5 || coin_reject_p !== 1'b0) begin failures++;
      $display("FAIL rst_idle credit=%0d rej=%b exp 5/0", credit, coin_reject_p); end
  endtask

  initial begin
    test_reset();
    test_exact_purchase();
    test_change();
    test_ceiling();
    test_short();
    test_coin_in_change();
    test_cancel();
    test_reset_in_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Central vending-machine controller: consumes the one-cycle, clk_dst-domain coin and cancel pulses produced by the per-input pulse synchronizers, accumulates credit, and accepts item selections. When a selection is affordable it issues a dispense pulse, then returns change through a valid/ack handshake. It sits directly downstream of the synchronizer bank and upstream of the dispenser and change-hopper drivers.

## Interface
- PRICE0, 15: price of item 0, cents
- PRICE1, 25: price of item 1, cents
- PRICE2, 35: price of item 2, cents
- PRICE3, 50: price of item 3, cents
- MAX_CREDIT, 95: credit ceiling, cents
- CREDIT_W, 7: credit and amount width; must hold MAX_CREDIT+25
- clk_dst  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- coin5_p, coin10_p, coin25_p  in  1 each  synchronized single-cycle coin pulses
- cancel_p  in  1  synchronized single-cycle cancel pulse
- sel_valid  in  1  selection request, level, sampled each cycle
- sel_item  in  2  item index, valid with sel_valid
- change_ack  in  1  hopper has taken change_amt
- credit  out  CREDIT_W  current credit
- dispense_p  out  1  one-cycle dispense strobe
- dispense_item  out  2  item being dispensed, valid with dispense_p
- change_valid  out  1  change pending
- change_amt  out  CREDIT_W  change value, stable while change_valid
- coin_reject_p  out  1  one-cycle strobe: the coins of that cycle were not credited
- short_p  out  1  one-cycle strobe: selection refused, credit too low

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), DISPENSE, CHANGE.
- Coin sum per cycle = 5·coin5_p + 10·coin10_p + 25·coin25_p; multiple simultaneous pulses are all summed.
- IDLE/CREDIT: if credit+sum ≤ MAX_CREDIT, add sum. Otherwise credit nothing from that cycle and pulse coin_reject_p. The check is all-or-nothing.
- Coins arriving in DISPENSE or CHANGE: not credited; coin_reject_p pulses.
- sel_valid in IDLE/CREDIT: compare pre-coin credit against PRICE[sel_item].
  - Credit ≥ price: new credit = credit + accepted sum − price; go to DISPENSE.
  - Credit < price: pulse short_p; state and credit are unchanged except for coin accumulation.
- DISPENSE lasts one cycle with dispense_p=1. Next state is CHANGE if credit>0, else IDLE.
- On entry to CHANGE: change_amt←credit, credit←0, change_valid←1. CHANGE holds until change_ack=1, then goes to IDLE and clears change_valid.
- change_ack outside CHANGE is ignored. sel_valid in DISPENSE/CHANGE is ignored, and short_p stays low.
- Cancel behaviour is defined under Configuration.
- Reset (any state): state IDLE; credit, change_amt and dispense_item are 0; all strobes and change_valid are 0. Credit in flight is discarded.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Coin pulse in cycle N: credit updates in cycle N+1, and coin_reject_p is high in N+1 when rejected.
- Accepted selection in cycle N: dispense_p, dispense_item and the reduced credit appear in N+1.
- CHANGE entry: change_valid and change_amt appear in N+2, and credit reads 0 in N+2.
- change_ack in cycle M: change_valid is low in M+1.
- short_p for a selection in cycle N is high in N+1. It repeats every cycle that sel_valid stays high.
- Minimum purchase with change: 3 cycles from selection to change_valid low with immediate ack.

## Configuration
- VEND_CANCEL_EN defined: cancel_p in CREDIT moves to CHANGE on the next edge (change_amt←credit, credit←0) and credits no coins that cycle. Cancel in IDLE, DISPENSE or CHANGE is ignored. cancel_p and sel_valid in the same cycle: cancel wins.
- Undefined: the cancel_p port remains but is ignored; credit is only ever returned as purchase change.

## Structure
- Package vend_pkg: state enum, coin value constants COIN5/COIN10/COIN25, price lookup function.
- Sub-module vend_credit_acc: coin summing, ceiling check, coin_reject_p generation.
- vend_ctrl holds the FSM, the selection compare and the change handshake.

## Test plan
- Pulses coin10 then coin5 → credit 10, then 15. Select item 0 → dispense_p with item 0, credit 0, back to IDLE, no change_valid.
- 25+25 (credit 50), select item 1 → dispense_p, then change_valid=1 with change_amt=25. Ack after 4 cycles → change_valid low next cycle, IDLE.
- Credit 90, coin10 → coin_reject_p, credit stays 90. coin5+coin10+coin25 pulsed together at credit 0 → credit 40.
- Credit 20, select item 2 → short_p, credit 20. Coin25 pulse during CHANGE → coin_reject_p, change_amt unchanged.
- VEND_CANCEL_EN, credit 35, cancel_p with sel_valid in the same cycle → CHANGE with change_amt=35, no dispense_p. Without the macro: no state change.
- Deassert rstn while in CHANGE → change_valid, credit and change_amt are 0 immediately, state IDLE.
